// File: rtl/addr_gen_nd.sv
// Three-level nested-loop address generator: addr = base + i0*s0 + i1*s1 + i2*s2 mod 2^AW, one address per cycle.
// First address is registered one cycle after start; process_stall freezes all state, abort ends the run without done.
module addr_gen_nd #(
   parameter int AW = 10,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] cfg_base,
   input  logic [CW-1:0] cfg_cnt0,
   input  logic [CW-1:0] cfg_cnt1,
   input  logic [CW-1:0] cfg_cnt2,
   input  logic [AW-1:0] cfg_stride0,
   input  logic [AW-1:0] cfg_stride1,
   input  logic [AW-1:0] cfg_stride2,
   input  logic          process_stall,
   output logic [AW-1:0] addr_out,
   output logic          addr_valid,
   output logic          busy,
   output logic          done
);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] a1_q, a1_d;
   logic [AW-1:0] a2_q, a2_d;
   logic [AW-1:0] s0_q, s0_d;
   logic [AW-1:0] s1_q, s1_d;
   logic [AW-1:0] s2_q, s2_d;
   logic [CW-1:0] lim0_q, lim0_d;
   logic [CW-1:0] lim1_q, lim1_d;
   logic [CW-1:0] lim2_q, lim2_d;
   logic [CW-1:0] i0_q, i0_d;
   logic [CW-1:0] i1_q, i1_d;
   logic [CW-1:0] i2_q, i2_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          at0, at1, at2;

   // Counts are stored as last index so a zero count behaves as one iteration.
   function automatic logic [CW-1:0] last_idx(input logic [CW-1:0] cnt);
      return (cnt == '0) ? '0 : cnt - CW'(1);
   endfunction

   always_comb begin
      at0 = (i0_q == lim0_q);
      at1 = (i1_q == lim1_q);
      at2 = (i2_q == lim2_q);
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      a1_d    = a1_q;
      a2_d    = a2_q;
      s0_d    = s0_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      lim0_d  = lim0_q;
      lim1_d  = lim1_q;
      lim2_d  = lim2_q;
      i0_d    = i0_q;
      i1_d    = i1_q;
      i2_d    = i2_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      if (state_q == ST_IDLE) begin
         if (start && !abort) begin
            state_d = ST_RUN;
            addr_d  = cfg_base;
            a1_d    = cfg_base;
            a2_d    = cfg_base;
            s0_d    = cfg_stride0;
            s1_d    = cfg_stride1;
            s2_d    = cfg_stride2;
            lim0_d  = last_idx(cfg_cnt0);
            lim1_d  = last_idx(cfg_cnt1);
            lim2_d  = last_idx(cfg_cnt2);
            i0_d    = '0;
            i1_d    = '0;
            i2_d    = '0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
         end
      end else begin
         if (abort) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end else if (valid_q && !process_stall) begin
            if (at0 && at1 && at2) begin
               // addr_out keeps the final address through the done cycle.
               state_d = ST_IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (!at0) begin
               i0_d   = i0_q + CW'(1);
               addr_d = addr_q + s0_q;
            end else if (!at1) begin
               i0_d   = '0;
               i1_d   = i1_q + CW'(1);
               a1_d   = a1_q + s1_q;
               addr_d = a1_q + s1_q;
            end else begin
               // Outer step re-anchors the middle loop at the new outer origin.
               i0_d   = '0;
               i1_d   = '0;
               i2_d   = i2_q + CW'(1);
               a2_d   = a2_q + s2_q;
               a1_d   = a2_q + s2_q;
               addr_d = a2_q + s2_q;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         a1_q    <= '0;
         a2_q    <= '0;
         s0_q    <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         lim0_q  <= '0;
         lim1_q  <= '0;
         lim2_q  <= '0;
         i0_q    <= '0;
         i1_q    <= '0;
         i2_q    <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         a1_q    <= a1_d;
         a2_q    <= a2_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         lim0_q  <= lim0_d;
         lim1_q  <= lim1_d;
         lim2_q  <= lim2_d;
         i0_q    <= i0_d;
         i1_q    <= i1_d;
         i2_q    <= i2_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign addr_out   = addr_q;
   assign addr_valid = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
